// File: rtl/uart_receptor.sv
// uart_receptor -- 8N1 UART receiver feeding the instruction handler.
//
// Each received byte is split into a 4-bit instruction code (upper nibble)
// and a 4-bit data value (lower nibble). Both are held until the next good
// frame or until the handler's clear output rises.
//
// Ports
//   clock       in   system clock, all logic on posedge
//   reset_n     in   synchronous active-low reset
//   rx          in   asynchronous serial line, idle high, LSB first
//   clear       in   rising edge zeroes instrucao/dado
//   instrucao   out  held instruction code (byte[7:4])
//   dado        out  held data value (byte[3:0])
//   valido      out  1-cycle pulse, new instrucao/dado loaded this cycle
//   erro_frame  out  1-cycle pulse, stop bit was low and the byte was dropped
//   ocupado     out  high whenever the receiver is not idle
module uart_receptor #(
  parameter int CLKS_PER_BIT = 434  // clock cycles per serial bit, >= 4 and even
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       rx,
  input  logic       clear,
  output logic [3:0] instrucao,
  output logic [3:0] dado,
  output logic       valido,
  output logic       erro_frame,
  output logic       ocupado
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    OCIOSO,  // idle, waiting for a start-bit falling edge
    INICIO,  // confirming the start bit at its centre
    DADOS,   // sampling the 8 data bits
    PARADA,  // sampling the stop bit
    ESPERA   // stop bit was low: wait for the line to return high
  } estado_t;

  estado_t          estado, estado_prox;
  logic             rx_meta, rx_s;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       idx;
  logic [7:0]       shift;
  logic             clear_d;
  logic             clear_edge;
  logic             zera_cnt;   // restart the bit-period counter
  logic             amostra;    // capture rx_s into shift[idx]
  logic             carrega;    // frame complete and good
  logic             falha;      // frame complete with a low stop bit

  // Two-flop synchroniser; idle level is high so a reset cannot fake a start.
  // NOTE: sequential state always uses non-blocking assignments so every flop
  // samples the pre-edge value of its neighbours, whatever the statement order.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) estado <= OCIOSO;
    else          estado <= estado_prox;
  end

  // Next-state and per-cycle control strobes.
  // NOTE: every signal written here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    estado_prox = estado;
    zera_cnt    = 1'b0;
    amostra     = 1'b0;
    carrega     = 1'b0;
    falha       = 1'b0;
    unique case (estado)
      OCIOSO: begin
        if (!rx_s) begin
          estado_prox = INICIO;
          zera_cnt    = 1'b1;
        end
      end
      INICIO: begin
        // Half a bit in: a still-low line is a real start bit, else a glitch.
        if (cnt == HALF_LAST) begin
          zera_cnt    = 1'b1;
          estado_prox = rx_s ? OCIOSO : DADOS;
        end
      end
      DADOS: begin
        if (cnt == BIT_LAST) begin
          zera_cnt = 1'b1;
          amostra  = 1'b1;
          if (idx == 3'd7) estado_prox = PARADA;
        end
      end
      PARADA: begin
        // Return to idle at mid-stop-bit so a back-to-back start is not missed.
        if (cnt == BIT_LAST) begin
          zera_cnt = 1'b1;
          if (rx_s) begin
            carrega     = 1'b1;
            estado_prox = OCIOSO;
          end else begin
            falha       = 1'b1;
            estado_prox = ESPERA;
          end
        end
      end
      ESPERA: begin
        if (rx_s) begin
          zera_cnt    = 1'b1;
          estado_prox = OCIOSO;
        end
      end
      default: begin
        estado_prox = OCIOSO;
        zera_cnt    = 1'b1;
      end
    endcase
  end

  // Bit-period counter: restarted on every transition and held at zero in the
  // states that do not time anything, so it can never wrap.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (zera_cnt || estado == OCIOSO || estado == ESPERA) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // Bit index is parked at zero outside DADOS, so each frame starts at bit 0.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      idx <= '0;
    end else if (estado != DADOS) begin
      idx <= '0;
    end else if (amostra) begin
      idx <= idx + 1'b1;
    end
  end

  // NOTE: the shift register is pure datapath with no reset; all eight bits
  // are rewritten by every frame before carrega can copy them out.
  always_ff @(posedge clock) begin
    if (amostra) shift[idx] <= rx_s;
  end

  assign clear_edge = clear & ~clear_d;

  // Held fields and status pulses. A completing frame has priority over a
  // coincident clear edge.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      clear_d    <= 1'b0;
      instrucao  <= '0;
      dado       <= '0;
      valido     <= 1'b0;
      erro_frame <= 1'b0;
    end else begin
      clear_d    <= clear;
      valido     <= carrega;
      erro_frame <= falha;
      if (carrega) begin
        instrucao <= shift[7:4];
        dado      <= shift[3:0];
      end else if (clear_edge) begin
        instrucao <= '0;
        dado      <= '0;
      end
    end
  end

  assign ocupado = (estado != OCIOSO);

endmodule

// File: tb/tb_uart_receptor.sv
// tb_uart_receptor -- self-checking bench for uart_receptor (CLKS_PER_BIT=16).
//
// A table of frames (data, stop-bit quality, idle gap, expected result) is
// driven in a loop; each frame pushes its expected pulse kind and held byte
// onto a scoreboard queue that a negedge monitor pops whenever valido or
// erro_frame fires. Hand-written sequences cover the start glitch, clear
// behaviour and a mid-frame reset.
module tb_uart_receptor;

  localparam int CPB = 16;

  logic       clock;
  logic       reset_n;
  logic       rx;
  logic       clear;
  logic [3:0] instrucao;
  logic [3:0] dado;
  logic       valido;
  logic       erro_frame;
  logic       ocupado;

  uart_receptor #(.CLKS_PER_BIT(CPB)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .rx         (rx),
    .clear      (clear),
    .instrucao  (instrucao),
    .dado       (dado),
    .valido     (valido),
    .erro_frame (erro_frame),
    .ocupado    (ocupado)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc = cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard entry: pulse kind and the byte the outputs must hold then.
  typedef struct packed {
    logic       err;
    logic [7:0] held;
  } exp_t;

  exp_t sb[$];
  int   n_valid = 0;
  int   n_err   = 0;
  int   n_exp_valid = 0;
  int   n_exp_err   = 0;
  int   last_valid_cyc = 0;
  int   start_cyc = 0;
  logic prev_pulse = 1'b0;

  task automatic expect_pulse(input logic err, input logic [7:0] held);
    sb.push_back(exp_t'({err, held}));
    if (err) n_exp_err++;
    else     n_exp_valid++;
  endtask

  // Monitor: every pulse must be single-cycle, exclusive and predicted.
  always @(negedge clock) begin
    if (!reset_n) begin
      prev_pulse = 1'b0;
    end else begin
      if (valido || erro_frame) begin
        exp_t e;
        check("pulse_exclusive", 32'(valido & erro_frame), 32'd0);
        check("pulse_width", 32'(prev_pulse), 32'd0);
        if (sb.size() == 0) begin
          check("unexpected_pulse", 32'({valido, erro_frame}), 32'd0);
        end else begin
          e = sb.pop_front();
          check("pulse_kind", 32'(erro_frame), 32'(e.err));
          check("held_byte", 32'({instrucao, dado}), 32'(e.held));
        end
        if (valido) begin
          n_valid++;
          last_valid_cyc = cyc;
        end
        if (erro_frame) n_err++;
      end
      prev_pulse = valido | erro_frame;
    end
  end

  // Called at a negedge; drives one 8N1 frame and returns at a negedge.
  task automatic send_frame(input logic [7:0] b, input bit stop_ok);
    start_cyc = cyc;
    rx = 1'b0;
    repeat (CPB) @(negedge clock);
    for (int k = 0; k < 8; k++) begin
      rx = b[k];
      repeat (CPB) @(negedge clock);
    end
    if (stop_ok) begin
      rx = 1'b1;
      repeat (CPB) @(negedge clock);
    end else begin
      rx = 1'b0;
      repeat (20) @(negedge clock);
      rx = 1'b1;
    end
  endtask

  typedef struct {
    logic [7:0] data;
    bit         stop_ok;
    int         gap;
    bit         exp_err;
    logic [3:0] exp_instr;
    logic [3:0] exp_dado;
  } vec_t;

  vec_t vecs[6];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int v0, e0, lat, c;

    vecs[0] = '{8'h2A, 1'b1, 4,  1'b0, 4'h2, 4'hA};
    vecs[1] = '{8'h14, 1'b0, 8,  1'b1, 4'h2, 4'hA};  // bad stop, keeps 0x2A
    vecs[2] = '{8'h14, 1'b1, 4,  1'b0, 4'h1, 4'h4};
    vecs[3] = '{8'h12, 1'b1, 0,  1'b0, 4'h1, 4'h2};  // back-to-back burst
    vecs[4] = '{8'h24, 1'b1, 0,  1'b0, 4'h2, 4'h4};
    vecs[5] = '{8'h4F, 1'b1, 20, 1'b0, 4'h4, 4'hF};

    rx      = 1'b1;
    clear   = 1'b0;
    reset_n = 1'b0;
    repeat (3) @(negedge clock);
    check("reset_instrucao", 32'(instrucao), 32'd0);
    check("reset_dado", 32'(dado), 32'd0);
    check("reset_valido", 32'(valido), 32'd0);
    check("reset_erro_frame", 32'(erro_frame), 32'd0);
    check("reset_ocupado", 32'(ocupado), 32'd0);
    reset_n = 1'b1;
    repeat (5) @(negedge clock);

    // Table-driven frames.
    for (int i = 0; i < 6; i++) begin
      expect_pulse(vecs[i].exp_err, {vecs[i].exp_instr, vecs[i].exp_dado});
      send_frame(vecs[i].data, vecs[i].stop_ok);
      repeat (vecs[i].gap) @(negedge clock);
      if (i == 0) begin
        lat = last_valid_cyc - start_cyc;
        check("latency_in_window", 32'(lat >= 153 && lat <= 156), 32'd1);
      end
      if (vecs[i].gap >= 4) begin
        check("idle_ocupado", 32'(ocupado), 32'd0);
        check("table_held", 32'({instrucao, dado}),
              32'({vecs[i].exp_instr, vecs[i].exp_dado}));
      end
    end
    check("table_valid_count", 32'(n_valid), 32'(n_exp_valid));
    check("table_err_count", 32'(n_err), 32'(n_exp_err));

    // Start-bit glitch: 5 low cycles must be rejected.
    v0 = n_valid;
    e0 = n_err;
    rx = 1'b0;
    repeat (5) @(negedge clock);
    rx = 1'b1;
    repeat (30) @(negedge clock);
    check("glitch_ocupado", 32'(ocupado), 32'd0);
    check("glitch_no_valido", 32'(n_valid), 32'(v0));
    check("glitch_no_erro", 32'(n_err), 32'(e0));
    expect_pulse(1'b0, 8'h41);
    send_frame(8'h41, 1'b1);
    repeat (4) @(negedge clock);
    check("after_glitch_held", 32'({instrucao, dado}), 32'h41);

    // Clear edge zeroes; held level has no further effect.
    expect_pulse(1'b0, 8'h4F);
    send_frame(8'h4F, 1'b1);
    repeat (4) @(negedge clock);
    clear = 1'b1;
    @(negedge clock);
    check("clear_zeroes", 32'({instrucao, dado}), 32'h00);
    repeat (10) @(negedge clock);
    expect_pulse(1'b0, 8'h2C);
    send_frame(8'h2C, 1'b1);
    repeat (4) @(negedge clock);
    check("clear_level_no_effect", 32'({instrucao, dado}), 32'h2C);
    clear = 1'b0;
    repeat (4) @(negedge clock);

    // Clear edge lands on the completion edge: new byte must win.
    expect_pulse(1'b0, 8'h37);
    c = cyc;
    fork
      send_frame(8'h37, 1'b1);
      begin
        repeat (154) @(negedge clock);
        clear = 1'b1;
      end
    join
    repeat (2) @(negedge clock);
    check("coincident_clear_held", 32'({instrucao, dado}), 32'h37);
    check("coincident_clear_timing", 32'(last_valid_cyc - c), 32'(155));
    clear = 1'b0;
    repeat (4) @(negedge clock);

    // Reset during the data bits of 0x4A; the bench abandons the frame too.
    v0 = n_valid;
    e0 = n_err;
    rx = 1'b0;                          // start bit
    repeat (CPB) @(negedge clock);
    rx = 1'b0;                          // bit 0 of 0x4A
    repeat (CPB) @(negedge clock);
    rx = 1'b1;                          // bit 1 of 0x4A
    repeat (10) @(negedge clock);
    reset_n = 1'b0;
    rx      = 1'b1;
    @(negedge clock);
    reset_n = 1'b1;
    repeat (200) @(negedge clock);
    check("midreset_outputs", 32'({instrucao, dado}), 32'h00);
    check("midreset_ocupado", 32'(ocupado), 32'd0);
    check("midreset_no_valido", 32'(n_valid), 32'(v0));
    check("midreset_no_erro", 32'(n_err), 32'(e0));
    expect_pulse(1'b0, 8'h4A);
    send_frame(8'h4A, 1'b1);
    repeat (4) @(negedge clock);
    check("after_reset_held", 32'({instrucao, dado}), 32'h4A);

    check("final_valid_count", 32'(n_valid), 32'(n_exp_valid));
    check("final_err_count", 32'(n_err), 32'(n_exp_err));
    check("scoreboard_empty", 32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
